// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment table and slot timing helpers for the seven-segment scanner
package seg7_pkg;

    // All segments dark (active-low drives).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low gfedcba patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        DIG0 = 1'b0,
        DIG1 = 1'b1
    } digit_e;

    typedef enum logic [1:0] {
        PH_BLANK = 2'd0,
        PH_ON    = 2'd1,
        PH_OFF   = 2'd2
    } phase_e;

    // Lit window length for a brightness level; level 15 fills the whole post-blank slot.
    function automatic int on_ticks_f(input int digit_ticks, input int blank_ticks, input logic [3:0] b);
        return ((digit_ticks - blank_ticks) * (int'(b) + 1)) >> 4;
    endfunction

    // Which part of the slot a given counter value falls into.
    function automatic phase_e slot_phase(input int t, input int blank_ticks, input int on_ticks);
        if (t < blank_ticks) begin
            return PH_BLANK;
        end else if (t < blank_ticks + on_ticks) begin
            return PH_ON;
        end else begin
            return PH_OFF;
        end
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - display value write handshake
interface seg7_scan_ctrl_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-low segment lookup
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Pure table lookup.
    always_comb begin
        seg_n = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - two-digit multiplexed seven-segment scanner with frame-aligned double buffer
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS = 12000,
    parameter int BLANK_TICKS = 240
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_ctrl_if.slave    wr,
    input  logic [3:0]         bright,
    input  logic               lz_blank,
    input  logic               en,
    output logic [6:0]         seg_n,
    output logic               dig_sel,
    output logic               frame_tick
);

    localparam int TW = $clog2(DIGIT_TICKS);

    logic [TW-1:0] t;
    logic [TW-1:0] t_nxt;
    digit_e        digit;
    digit_e        digit_nxt;
    logic [3:0]    bright_q;
    logic [3:0]    bright_nxt;
    logic [7:0]    disp;
    logic [7:0]    disp_nxt;
    logic [7:0]    pending;
    logic          pend_v;
    logic          wrap;
    logic          frame;
    logic          xfer;
    logic [3:0]    nib;
    logic [6:0]    dec_seg;
    phase_e        phase_nxt;
    logic          seg_on;

    assign wr.wr_ready = !pend_v;

    seg7_hex_decode u_dec (
        .nibble (nib),
        .seg_n  (dec_seg)
    );

    // Next-state view: outputs are registered from the state being entered, so they line up with (t, digit).
    always_comb begin
        wrap       = (t == TW'(DIGIT_TICKS - 1));
        frame      = wrap && (digit == DIG1);
        xfer       = wr.wr_valid && !pend_v;
        t_nxt      = wrap ? '0 : t + 1'b1;
        digit_nxt  = wrap ? ((digit == DIG0) ? DIG1 : DIG0) : digit;
        bright_nxt = wrap ? bright : bright_q;
        disp_nxt   = (frame && pend_v) ? pending : disp;
        nib        = (digit_nxt == DIG1) ? disp_nxt[7:4] : disp_nxt[3:0];
        phase_nxt  = slot_phase(32'(t_nxt), BLANK_TICKS, on_ticks_f(DIGIT_TICKS, BLANK_TICKS, bright_nxt));
        seg_on     = (phase_nxt == PH_ON) && en &&
                     !(lz_blank && (digit_nxt == DIG1) && (disp_nxt[7:4] == 4'h0));
    end

    // Slot counter, digit FSM, write buffer, frame commit and registered pin drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t          <= '0;
            digit      <= DIG0;
            bright_q   <= 4'hF;
            disp       <= 8'h00;
            pending    <= 8'h00;
            pend_v     <= 1'b0;
            seg_n      <= SEG_OFF;
            dig_sel    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            t          <= t_nxt;
            digit      <= digit_nxt;
            bright_q   <= bright_nxt;
            disp       <= disp_nxt;
            if (xfer) begin
                pending <= wr.wr_data;
            end
            // A transfer can only happen while empty, so it never collides with a commit.
            pend_v     <= xfer || (pend_v && !frame);
            seg_n      <= seg_on ? dec_seg : SEG_OFF;
            dig_sel    <= (digit_nxt == DIG1);
            frame_tick <= frame;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    localparam int DT = 32;
    localparam int BT = 4;
    localparam logic [6:0] OFF = 7'h7F;

    typedef struct packed {
        logic       dig;
        logic [6:0] val;
        int         first;
        int         last;
        logic       ft0;
        logic       ftx;
        logic       bad;
    } rec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] bright;
    logic       lz_blank;
    logic       en;
    logic [6:0] seg_n;
    logic       dig_sel;
    logic       frame_tick;

    seg7_scan_ctrl_if wr_if ();

    seg7_scan_ctrl #(
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (wr_if),
        .bright     (bright),
        .lz_blank   (lz_blank),
        .en         (en),
        .seg_n      (seg_n),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    int         tests = 0;
    int         fails = 0;
    rec_t       exp_q[$];
    logic [7:0] wq[$];
    rec_t       cur;
    int         cnt;
    bit         active = 0;
    int         slot_no = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task close_slot();
        rec_t e;
        tests++;
        slot_no++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL slot%0d unexpected: dig=%0d val=%h lit=%0d..%0d", slot_no, cur.dig, cur.val, cur.first, cur.last);
        end else begin
            e = exp_q.pop_front();
            if (cur != e) begin
                fails++;
                $display("FAIL slot%0d: got dig=%0d val=%h lit=%0d..%0d ft0=%0d ftx=%0d bad=%0d, expected dig=%0d val=%h lit=%0d..%0d ft0=%0d ftx=0 bad=0",
                         slot_no, cur.dig, cur.val, cur.first, cur.last, cur.ft0, cur.ftx, cur.bad,
                         e.dig, e.val, e.first, e.last, e.ft0);
            end
        end
    endtask

    // Monitor: summarise each digit slot (lit window, pattern, frame pulse) and score it against the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
        end else begin
            if (active && (dig_sel != cur.dig)) begin
                close_slot();
                active = 0;
            end
            if (!active) begin
                cur.dig   = dig_sel;
                cur.val   = OFF;
                cur.first = -1;
                cur.last  = -1;
                cur.ft0   = frame_tick;
                cur.ftx   = 1'b0;
                cur.bad   = 1'b0;
                cnt       = 0;
                active    = 1;
            end else begin
                cnt++;
                if (frame_tick) cur.ftx = 1'b1;
            end
            if (seg_n != OFF) begin
                if (cur.first < 0) begin
                    cur.first = cnt;
                    cur.val   = seg_n;
                end else if (seg_n != cur.val || cur.last != cnt - 1) begin
                    cur.bad = 1'b1;
                end
                cur.last = cnt;
            end
        end
    end

    task automatic run_cycles(input int n, input int wr_from, input int rdy_cyc, input logic rdy_exp);
        logic acc;
        for (int i = 0; i < n; i++) begin
            if (!wr_if.wr_valid && wq.size() > 0 && i >= wr_from) begin
                wr_if.wr_data  = wq.pop_front();
                wr_if.wr_valid = 1'b1;
            end
            if (i == rdy_cyc) check("wr_ready", int'(wr_if.wr_ready), int'(rdy_exp));
            acc = wr_if.wr_valid && wr_if.wr_ready;
            @(posedge clk);
            #1;
            if (acc) wr_if.wr_valid = 1'b0;
        end
    endtask

    task automatic slot(input logic dig, input logic [6:0] val, input int first, input int last,
                        input logic ft0, input int wr_from, input int rdy_cyc, input logic rdy_exp);
        rec_t r;
        r = '{dig: dig, val: val, first: first, last: last, ft0: ft0, ftx: 1'b0, bad: 1'b0};
        exp_q.push_back(r);
        run_cycles(DT, wr_from, rdy_cyc, rdy_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        bright         = 4'd15;
        lz_blank       = 1'b0;
        en             = 1'b1;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg_n", int'(seg_n), int'(OFF));
        check("rst_dig_sel", int'(dig_sel), 0);
        check("rst_wr_ready", int'(wr_if.wr_ready), 1);
        check("rst_frame_tick", int'(frame_tick), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        slot(0, 7'h40, BT, DT-1, 0, 0, -1, 0);          // S1 reset value 00
        wq.push_back(8'h3A);
        slot(1, 7'h40, BT, DT-1, 0, 0, 2, 0);           // S2 write 3A, ready falls
        slot(0, 7'h08, BT, DT-1, 1, 0, 0, 1);           // S3 commit, ready back high
        bright = 4'd7;
        slot(1, 7'h30, BT, DT-1, 0, 0, -1, 0);          // S4 still full brightness
        bright = 4'd0;
        slot(0, 7'h08, BT, BT+13, 1, 0, -1, 0);         // S5 bright 7: 14 ticks
        bright = 4'd15;
        slot(1, 7'h30, BT, BT, 0, 0, -1, 0);            // S6 bright 0: 1 tick
        slot(0, 7'h08, BT, DT-1, 1, 0, -1, 0);          // S7 full again
        wq.push_back(8'h12);
        wq.push_back(8'h34);
        slot(1, 7'h30, BT, DT-1, 0, 0, 5, 0);           // S8 12 taken, 34 held off
        slot(0, 7'h24, BT, DT-1, 1, 0, 2, 0);           // S9 12 shown, 34 taken after commit
        slot(1, 7'h79, BT, DT-1, 0, 0, -1, 0);          // S10
        slot(0, 7'h19, BT, DT-1, 1, 0, -1, 0);          // S11 34 shown
        wq.push_back(8'h56);
        slot(1, 7'h30, BT, DT-1, 0, DT-1, DT-1, 1);     // S12 write on the frame edge
        slot(0, 7'h19, BT, DT-1, 1, 0, 0, 0);           // S13 old value kept
        slot(1, 7'h30, BT, DT-1, 0, 0, -1, 0);          // S14
        slot(0, 7'h02, BT, DT-1, 1, 0, -1, 0);          // S15 56 shown
        wq.push_back(8'h05);
        lz_blank = 1'b1;
        slot(1, 7'h12, BT, DT-1, 0, 0, -1, 0);          // S16 nibble 5 not blanked
        slot(0, 7'h12, BT, DT-1, 1, 0, -1, 0);          // S17 05 shown
        slot(1, OFF, -1, -1, 0, 0, -1, 0);              // S18 leading zero blanked
        lz_blank = 1'b0;
        slot(0, 7'h12, BT, DT-1, 1, 0, -1, 0);          // S19
        en = 1'b0;
        slot(1, OFF, -1, -1, 0, 0, -1, 0);              // S20 display disabled
        en = 1'b1;
        slot(0, 7'h12, BT, DT-1, 1, 0, -1, 0);          // S21

        wq.push_back(8'h77);
        run_cycles(10, 0, 5, 0);                         // S22 digit 1 ON, 77 pending
        check("seg_before_rst", int'(seg_n), 32'h40);
        rst_n = 1'b0;
        #1;
        check("midrst_seg_n", int'(seg_n), int'(OFF));
        check("midrst_dig_sel", int'(dig_sel), 0);
        check("midrst_wr_ready", int'(wr_if.wr_ready), 1);
        check("midrst_frame_tick", int'(frame_tick), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        slot(0, 7'h40, BT, DT-1, 0, 0, 0, 1);           // S23 pending 77 discarded
        slot(1, 7'h40, BT, DT-1, 0, 0, -1, 0);          // S24
        run_cycles(2, 0, -1, 0);
        check("scoreboard_leftover", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
